// File: rtl/rtc_time_ctrl.sv
// rtc_time_ctrl: BCD time-of-day counter with a two-button set mode.
// Drives digit codes, seconds and a blink blank mask for a 4-digit display.
module rtc_time_ctrl #(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       btn_mode_i,
  input  logic       btn_inc_i,
  output logic [3:0] sign0_o,
  output logic [3:0] sign1_o,
  output logic [3:0] sign2_o,
  output logic [3:0] sign3_o,
  output logic [5:0] seconds_o,
  output logic [3:0] blank_o,
  output logic [1:0] mode_o
);

  localparam int unsigned HALF = CLK_HZ / 2;
  localparam int unsigned PW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int unsigned SW   = 6;
  localparam int unsigned DW   = 4;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SET_HH = 2'd1,
    SET_MM = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic            phase_q, phase_d;
  logic [SW-1:0]   sec_q,   sec_d;
  logic [DW-1:0]   m0_q, m0_d;
  logic [DW-1:0]   m1_q, m1_d;
  logic [DW-1:0]   h0_q, h0_d;
  logic [DW-1:0]   h1_q, h1_d;
  logic [3:0]      blank_q, blank_d;

  logic            half_tick;
  logic            sec_tick;
  logic [8:0]      min_nxt;
  logic [7:0]      hr_nxt;

  // Minutes +1 in BCD; bit 8 is the 59->00 carry into hours.
  function automatic logic [8:0] bcd_inc_min(input logic [3:0] t, input logic [3:0] u);
    logic [8:0] r;
    r = {1'b0, t, u + 4'd1};
    if (u == 4'd9) begin
      if (t == 4'd5) r = 9'h100;
      else           r = {1'b0, t + 4'd1, 4'd0};
    end
    return r;
  endfunction

  // Hours +1 in BCD, wrapping 23->00.
  function automatic logic [7:0] bcd_inc_hr(input logic [3:0] t, input logic [3:0] u);
    logic [7:0] r;
    if ((t == 4'd2) && (u == 4'd3)) r = 8'h00;
    else if (u == 4'd9)             r = {t + 4'd1, 4'd0};
    else                            r = {t, u + 4'd1};
    return r;
  endfunction

  assign half_tick = (presc_q == PW'(HALF - 1));
  assign sec_tick  = half_tick & phase_q;
  assign min_nxt   = bcd_inc_min(m1_q, m0_q);
  assign hr_nxt    = bcd_inc_hr(h1_q, h0_q);

  // State, counters and registered outputs; synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= RUN;
      presc_q <= '0;
      phase_q <= 1'b0;
      sec_q   <= '0;
      m0_q    <= '0;
      m1_q    <= '0;
      h0_q    <= '0;
      h1_q    <= '0;
      blank_q <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      phase_q <= phase_d;
      sec_q   <= sec_d;
      m0_q    <= m0_d;
      m1_q    <= m1_d;
      h0_q    <= h0_d;
      h1_q    <= h1_d;
      blank_q <= blank_d;
    end
  end

  // Next-state: prescaler, mode sequencing, timekeeping and field edits.
  always_comb begin
    state_d = state_q;
    sec_d   = sec_q;
    m0_d    = m0_q;
    m1_d    = m1_q;
    h0_d    = h0_q;
    h1_d    = h1_q;
    blank_d = 4'b0000;

    // Free-running half-second prescaler; phase selects the second half.
    if (half_tick) begin
      presc_d = '0;
      phase_d = ~phase_q;
    end else begin
      presc_d = presc_q + PW'(1);
      phase_d = phase_q;
    end

    case (state_q)
      RUN: begin
        // A tick on the same edge as the mode press is still counted.
        if (sec_tick) begin
          if (sec_q == SW'(59)) begin
            sec_d = '0;
            m1_d  = min_nxt[7:4];
            m0_d  = min_nxt[3:0];
            if (min_nxt[8]) begin
              h1_d = hr_nxt[7:4];
              h0_d = hr_nxt[3:0];
            end
          end else begin
            sec_d = sec_q + SW'(1);
          end
        end
        if (btn_mode_i) state_d = SET_HH;
      end
      SET_HH: begin
        if (btn_mode_i) begin
          state_d = SET_MM;
        end else if (btn_inc_i) begin
          h1_d    = hr_nxt[7:4];
          h0_d    = hr_nxt[3:0];
          presc_d = '0;
          phase_d = 1'b0;
        end
      end
      SET_MM: begin
        // Leaving set mode restarts the minute at this edge.
        if (btn_mode_i) begin
          state_d = RUN;
          sec_d   = '0;
          presc_d = '0;
          phase_d = 1'b0;
        end else if (btn_inc_i) begin
          m1_d    = min_nxt[7:4];
          m0_d    = min_nxt[3:0];
          presc_d = '0;
          phase_d = 1'b0;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase

    // Blank the edited field during the second half of each second.
    case (state_d)
      SET_HH:  blank_d = phase_d ? 4'b1100 : 4'b0000;
      SET_MM:  blank_d = phase_d ? 4'b0011 : 4'b0000;
      default: blank_d = 4'b0000;
    endcase
  end

  assign sign0_o   = m0_q;
  assign sign1_o   = m1_q;
  assign sign2_o   = h0_q;
  assign sign3_o   = h1_q;
  assign seconds_o = sec_q;
  assign blank_o   = blank_q;
  assign mode_o    = state_q;

endmodule
